// File: rtl/key_pkg.sv
// key_pkg: shared constants for the keyboard event tracker.
//   KEY_CODES    - USB keycode for each tracked key. Entry i is key i.
//   KEY_*        - index of each named key in KEY_CODES and in the output vectors.
//   ROLLOVER_CODE- the code the keyboard reports in every slot on phantom-key rollover.
//   rpt_state_e  - per-key auto-repeat FSM states.
package key_pkg;

   localparam int KEY_COUNT = 9;

   localparam int KEY_P1_LEFT  = 0;
   localparam int KEY_P1_RIGHT = 1;
   localparam int KEY_P1_ATK1  = 2;
   localparam int KEY_P1_ATK2  = 3;
   localparam int KEY_P2_LEFT  = 4;
   localparam int KEY_P2_RIGHT = 5;
   localparam int KEY_P2_ATK1  = 6;
   localparam int KEY_P2_ATK2  = 7;
   localparam int KEY_ENTER    = 8;

   // Entry 0 sits in the least significant byte.
   localparam logic [KEY_COUNT-1:0][7:0] KEY_CODES = {
      8'h28,                            // enter
      8'h5A, 8'h59, 8'h4F, 8'h50,       // P2 atk2, atk1, right, left
      8'h0B, 8'h0A, 8'h07, 8'h04        // P1 atk2, atk1, right, left
   };

   localparam logic [7:0] ROLLOVER_CODE = 8'h01;

   typedef enum logic [1:0] {
      RPT_IDLE   = 2'd0,
      RPT_DELAY  = 2'd1,
      RPT_REPEAT = 2'd2
   } rpt_state_e;

endpackage

// File: rtl/key_repeat_fsm.sv
// key_repeat_fsm: auto-repeat timer for one key.
//   Clk, Reset      - clock, synchronous active-high reset
//   step_i          - an accepted sample is being taken this cycle
//   hit_i           - the key is present in that sample
//   repeat_pulse_o  - registered one-cycle repeat pulse
// The timer only advances on accepted samples, so it counts frames, not clocks.
module key_repeat_fsm
   import key_pkg::*;
#(
   parameter int REPEAT_DELAY  = 20,
   parameter int REPEAT_PERIOD = 4
) (
   input  logic Clk,
   input  logic Reset,
   input  logic step_i,
   input  logic hit_i,
   output logic repeat_pulse_o
);

   localparam int CW = $clog2((REPEAT_DELAY > REPEAT_PERIOD) ? REPEAT_DELAY : REPEAT_PERIOD) + 1;

   rpt_state_e    state_q;
   logic [CW-1:0] cnt_q;
   logic          pulse_q;

   always_ff @(posedge Clk) begin
      if (Reset) begin
         state_q <= RPT_IDLE;
         cnt_q   <= '0;
         pulse_q <= 1'b0;
      end else begin
         pulse_q <= 1'b0;
         if (step_i) begin
            if (!hit_i) begin
               state_q <= RPT_IDLE;
               cnt_q   <= '0;
            end else begin
               case (state_q)
                  RPT_IDLE: begin
                     // The press sample itself counts as sample 1 of the delay.
                     state_q <= RPT_DELAY;
                     cnt_q   <= CW'(1);
                  end
                  RPT_DELAY: begin
                     if (cnt_q == CW'(REPEAT_DELAY)) begin
                        state_q <= RPT_REPEAT;
                        cnt_q   <= CW'(1);
                        pulse_q <= 1'b1;
                     end else begin
                        cnt_q <= cnt_q + CW'(1);
                     end
                  end
                  RPT_REPEAT: begin
                     if (cnt_q == CW'(REPEAT_PERIOD)) begin
                        cnt_q   <= CW'(1);
                        pulse_q <= 1'b1;
                     end else begin
                        cnt_q <= cnt_q + CW'(1);
                     end
                  end
                  default: begin
                     state_q <= RPT_IDLE;
                     cnt_q   <= '0;
                  end
               endcase
            end
         end
      end
   end

   assign repeat_pulse_o = pulse_q;

endmodule

// File: rtl/key_event_tracker.sv
// key_event_tracker: frame-sampled keyboard front end.
//   Clk, Reset    - clock, synchronous active-high reset
//   keycode       - NUM_SLOTS 8-bit keycode slots, slot k at [8k+7:8k], 8'h00 empty
//   sample_en     - keycode is evaluated only in cycles where this is high
//   held          - key present in the last accepted sample
//   pressed       - one-cycle pulse on a 0->1 change of held
//   released      - one-cycle pulse on a 1->0 change of held
//   repeat_pulse  - one-cycle auto-repeat pulse per key
//   rollover_err  - one-cycle pulse when a sample is rejected as rollover
// All outputs are registered; a sample in cycle t shows up in cycle t+1.
module key_event_tracker
   import key_pkg::*;
#(
   parameter int NUM_SLOTS     = 4,
   parameter int NUM_KEYS      = 9,
   parameter int REPEAT_DELAY  = 20,
   parameter int REPEAT_PERIOD = 4
) (
   input  logic                   Clk,
   input  logic                   Reset,
   input  logic [8*NUM_SLOTS-1:0] keycode,
   input  logic                   sample_en,
   output logic [NUM_KEYS-1:0]    held,
   output logic [NUM_KEYS-1:0]    pressed,
   output logic [NUM_KEYS-1:0]    released,
   output logic [NUM_KEYS-1:0]    repeat_pulse,
   output logic                   rollover_err
);

   logic [NUM_KEYS-1:0] hit;
   logic                rollover;
   logic                accept;

   logic [NUM_KEYS-1:0] held_q, held_d;
   logic [NUM_KEYS-1:0] pressed_q, released_q;
   logic                rollover_q;

   // A code repeated across slots still yields a single hit; 8'h00 never matches.
   always_comb begin
      hit = '0;
      for (int i = 0; i < NUM_KEYS; i++) begin
         for (int k = 0; k < NUM_SLOTS; k++) begin
            if (KEY_CODES[i] != 8'h00 && keycode[8*k +: 8] == KEY_CODES[i])
               hit[i] = 1'b1;
         end
      end
   end

   always_comb begin
      rollover = 1'b1;
      for (int k = 0; k < NUM_SLOTS; k++) begin
         if (keycode[8*k +: 8] != ROLLOVER_CODE)
            rollover = 1'b0;
      end
   end

   // A rollover sample is dropped entirely: no state moves anywhere.
   assign accept = sample_en & ~rollover;
   assign held_d = accept ? hit : held_q;

   always_ff @(posedge Clk) begin
      if (Reset) begin
         held_q     <= '0;
         pressed_q  <= '0;
         released_q <= '0;
         rollover_q <= 1'b0;
      end else begin
         held_q     <= held_d;
         pressed_q  <= accept ? (hit & ~held_q) : '0;
         released_q <= accept ? (~hit & held_q) : '0;
         rollover_q <= sample_en & rollover;
      end
   end

   for (genvar g = 0; g < NUM_KEYS; g++) begin : g_key
      key_repeat_fsm #(
         .REPEAT_DELAY  (REPEAT_DELAY),
         .REPEAT_PERIOD (REPEAT_PERIOD)
      ) u_rpt (
         .Clk            (Clk),
         .Reset          (Reset),
         .step_i         (accept),
         .hit_i          (hit[g]),
         .repeat_pulse_o (repeat_pulse[g])
      );
   end

   assign held         = held_q;
   assign pressed      = pressed_q;
   assign released     = released_q;
   assign rollover_err = rollover_q;

endmodule

// File: tb/tb_key_event_tracker.sv
// Scoreboard bench: the stimulus process drives one cycle at a time, runs a
// frame-age reference model and queues the expected outputs; a monitor pops
// and compares them one cycle later.
module tb_key_event_tracker;

   localparam int NS = 4;
   localparam int NK = 9;
   localparam int RD = 20;
   localparam int RP = 4;

   localparam logic [7:0] CODES [NK] = '{8'h04, 8'h07, 8'h0A, 8'h0B,
                                         8'h50, 8'h4F, 8'h59, 8'h5A, 8'h28};

   logic            Clk = 1'b0;
   logic            Reset = 1'b1;
   logic [8*NS-1:0] keycode = '0;
   logic            sample_en = 1'b0;
   logic [NK-1:0]   held, pressed, released, repeat_pulse;
   logic            rollover_err;

   key_event_tracker #(
      .NUM_SLOTS(NS), .NUM_KEYS(NK), .REPEAT_DELAY(RD), .REPEAT_PERIOD(RP)
   ) dut (
      .Clk(Clk), .Reset(Reset), .keycode(keycode), .sample_en(sample_en),
      .held(held), .pressed(pressed), .released(released),
      .repeat_pulse(repeat_pulse), .rollover_err(rollover_err)
   );

   always #5 Clk = ~Clk;

   typedef struct {
      int            cyc;
      logic [NK-1:0] h, p, r, rp;
      logic          ro;
   } exp_t;

   exp_t q[$];
   int   cyc_cnt = 0;
   int   tests = 0;
   int   fails = 0;

   // Reference model: per key, whether it is down and how many accepted
   // samples have passed since its press.
   bit mh [NK];
   int mage [NK];

   initial forever begin
      @(posedge Clk);
      cyc_cnt = cyc_cnt + 1;
   end

   task automatic step(input logic [31:0] kc, input bit en, input bit rst);
      exp_t e;
      bit   hit;
      bit   ro;
      @(posedge Clk);
      #1;
      Reset     = rst;
      keycode   = kc;
      sample_en = en;
      e.cyc = cyc_cnt;
      e.h = '0; e.p = '0; e.r = '0; e.rp = '0; e.ro = 1'b0;
      ro = 1'b1;
      for (int k = 0; k < NS; k++)
         if (kc[8*k +: 8] != 8'h01) ro = 1'b0;
      if (rst) begin
         for (int i = 0; i < NK; i++) begin
            mh[i] = 1'b0;
            mage[i] = 0;
         end
      end else begin
         if (en && ro) e.ro = 1'b1;
         for (int i = 0; i < NK; i++) begin
            hit = 1'b0;
            for (int k = 0; k < NS; k++)
               if (CODES[i] != 8'h00 && kc[8*k +: 8] == CODES[i]) hit = 1'b1;
            if (en && !ro) begin
               e.p[i] = hit && !mh[i];
               e.r[i] = !hit && mh[i];
               if (hit) mage[i] = mh[i] ? mage[i] + 1 : 0;
               e.rp[i] = hit && mage[i] >= RD && ((mage[i] - RD) % RP) == 0;
               mh[i] = hit;
            end
            e.h[i] = mh[i];
         end
      end
      q.push_back(e);
   endtask

   initial forever begin
      exp_t e;
      @(negedge Clk);
      while (q.size() > 0 && q[0].cyc < cyc_cnt) begin
         e = q.pop_front();
         tests = tests + 1;
         if (held !== e.h || pressed !== e.p || released !== e.r ||
             repeat_pulse !== e.rp || rollover_err !== e.ro) begin
            fails = fails + 1;
            $display("FAIL outputs cyc%0d got h=%h p=%h r=%h rp=%h ro=%b want h=%h p=%h r=%h rp=%h ro=%b",
                     e.cyc, held, pressed, released, repeat_pulse, rollover_err,
                     e.h, e.p, e.r, e.rp, e.ro);
         end
      end
   end

   function automatic logic [7:0] pick_code();
      int r;
      r = $urandom_range(0, 9);
      if (r <= 4) return CODES[$urandom_range(0, NK-1)];
      else if (r <= 6) return 8'h00;
      else if (r == 7) return 8'h01;
      else return 8'($urandom_range(0, 255));
   endfunction

   initial begin
      logic [31:0] cur;
      logic [31:0] kc;
      int          s;

      // Reset state
      step(32'h0, 1'b0, 1'b1);
      step(32'h0, 1'b1, 1'b1);

      // Single press, then idle cycles between strobes
      step(32'h0000_0004, 1'b1, 1'b0);
      step(32'h0000_0004, 1'b0, 1'b0);
      step(32'h0000_0000, 1'b1, 1'b0);

      // Two presses together, then release of one
      step(32'h0004_0007, 1'b1, 1'b0);
      step(32'h0000_0007, 1'b1, 1'b0);
      step(32'h0000_0000, 1'b1, 1'b0);

      // Hold enter for 30 samples with gaps, then release
      for (int n = 0; n < 30; n++) begin
         step(32'h0000_0028, 1'b1, 1'b0);
         if (n % 3 == 0) step(32'h0000_0028, 1'b0, 1'b0);
      end
      step(32'h0000_0000, 1'b1, 1'b0);

      // Rollover while P2_LEFT held: repeat schedule must shift by the rejected samples
      for (int n = 0; n < 18; n++) step(32'h0000_0050, 1'b1, 1'b0);
      step(32'h0101_0101, 1'b1, 1'b0);
      step(32'h0101_0101, 1'b1, 1'b0);
      for (int n = 0; n < 8; n++) step(32'h0000_0050, 1'b1, 1'b0);
      step(32'h0000_0000, 1'b1, 1'b0);

      // Reset mid-repeat with key still down
      for (int n = 0; n < 24; n++) step(32'h0000_0059, 1'b1, 1'b0);
      step(32'h0000_0059, 1'b1, 1'b1);
      step(32'h0000_0059, 1'b1, 1'b1);
      for (int n = 0; n < 22; n++) step(32'h0000_0059, 1'b1, 1'b0);
      step(32'h0000_0000, 1'b1, 1'b0);

      // Duplicate code in two slots, keycode churn between strobes
      step(32'h0A0A_0000, 1'b1, 1'b0);
      step(32'h1234_5678, 1'b0, 1'b0);
      step(32'h0B00_0000, 1'b0, 1'b0);
      step(32'h0101_0101, 1'b0, 1'b0);
      step(32'h0A0A_0000, 1'b1, 1'b0);
      step(32'h0000_0000, 1'b1, 1'b0);

      // Randomized: sticky slot contents so keys stay down long enough to repeat
      cur = 32'h0;
      for (int n = 0; n < 4000; n++) begin
         if ($urandom_range(0, 3) == 0) begin
            s = $urandom_range(0, NS-1);
            cur[8*s +: 8] = pick_code();
         end
         kc = ($urandom_range(0, 39) == 0) ? 32'h0101_0101 : cur;
         step(kc, ($urandom_range(0, 2) != 0), ($urandom_range(0, 299) == 0));
      end

      // Drain: everything queued must have been checked
      repeat (3) @(posedge Clk);
      @(negedge Clk);
      tests = tests + 1;
      if (q.size() != 0) begin
         fails = fails + 1;
         $display("FAIL drain pending=%0d want 0", q.size());
      end

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule
